// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor built from one full-subtractor
// cell and a borrow flop. Computes diff = (a - b - borrow_in) mod 2^WIDTH and
// borrow_out = (a < b + borrow_in), one operand bit pair per clock, LSB first.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the ovf output, the
// two's-complement signed overflow of a - b - borrow_in.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low. in_ready is high only in IDLE; out_valid is
// high only in DONE, and diff/borrow_out(/ovf) are stable for as long as it is.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must reach WIDTH-1 without wrapping; at least one bit wide.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the result bits produced so far except the one being computed now;
  // the final bit is merged straight into diff on the last RUN edge.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_shift;
  logic             br;

  logic             d_bit;
  logic             br_nxt;
  logic             last_bit;
  logic             accept;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    d_bit     = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_shift = {d_bit, res_sr};
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  assign accept = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, publish on last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= borrow_in;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift[WIDTH-1:1];
          br     <= br_nxt;
          cnt    <= last_bit ? '0 : cnt + CW'(1);
          if (last_bit) begin
            diff       <= res_shift;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (a_msb != b_msb) & (d_bit != a_msb);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// (WIDTH=8) against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         ovf_obs;

  int checks = 0;
  int errors = 0;

  // {ovf, borrow_out, diff}
  logic [W+1:0] exp_q[$];

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed for ovf.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rbin);
    int ud;
    int sa;
    int sb;
    int sd;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    ud = int'(ra) - int'(rb) - int'(rbin);
    bo = (ud < 0);
    d  = W'(ud);
    sa = int'(ra) - (ra[W-1] ? (1 << W) : 0);
    sb = int'(rb) - (rb[W-1] ? (1 << W) : 0);
    sd = sa - sb - int'(rbin);
    ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return {ov, bo, d};
  endfunction

  // Driver: called at a negedge; presents operands until accepted.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    a         = ta;
    b         = tb;
    borrow_in = tbin;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Waits for out_valid; cyc counts rising edges including the accept edge.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (diff !== 8'h00)      begin errors++; $display("FAIL reset_diff got %h exp 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow_out); end
    checks++; if (ovf_obs !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_obs); end
  endtask

  task automatic test_latency();
    int cyc;
    out_ready = 1'b1;
    send(8'h05, 8'h03, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got %b exp 1", busy); end
    wait_out(cyc);
    checks++; if (cyc != W + 1)        begin errors++; $display("FAIL latency_cycles got %0d exp %0d", cyc, W + 1); end
    checks++; if (diff !== 8'h02)      begin errors++; $display("FAIL latency_diff got %h exp 02", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL latency_borrow got %b exp 0", borrow_out); end
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL latency_in_ready_done got %b exp 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL latency_out_valid_after got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL latency_in_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[3]  = '{8'h03, 8'h00, 8'hFF};
    logic [W-1:0] vb[3]  = '{8'h05, 8'h00, 8'hFF};
    logic         vc[3]  = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] ed[3]  = '{8'hFE, 8'hFF, 8'h00};
    logic         eb[3]  = '{1'b1, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vc[i]);
      wait_out(cyc);
      checks++; if (diff !== ed[i])       begin errors++; $display("FAIL directed_diff[%0d] got %h exp %h", i, diff, ed[i]); end
      checks++; if (borrow_out !== eb[i]) begin errors++; $display("FAIL directed_borrow[%0d] got %b exp %b", i, borrow_out, eb[i]); end
      take();
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    bit held_ok;
    send(8'hA0, 8'h0F, 1'b0);
    wait_out(cyc);
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || diff !== 8'h91 || borrow_out !== 1'b0 || in_ready !== 1'b0) begin
        held_ok = 1'b0;
        $display("FAIL bp_hold[%0d] got v=%b d=%h bo=%b ir=%b exp v=1 d=91 bo=0 ir=0",
                 i, out_valid, diff, borrow_out, in_ready);
      end
      @(negedge clk);
    end
    checks++; if (!held_ok) errors++;
    take();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_released got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_in_ready got %b exp 1", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer got %b exp 0", out_valid); end
    checks++; if (diff !== 8'h91)     begin errors++; $display("FAIL bp_diff_retained got %h exp 91", diff); end
  endtask

  task automatic test_in_valid_ignored();
    int cyc;
    logic [W+1:0] e;
    e = ref_model(8'h3C, 8'h15, 1'b1);
    send(8'h3C, 8'h15, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid  = ~in_valid;
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(cyc);
    checks++; if (diff !== e[W-1:0])     begin errors++; $display("FAIL ignore_diff got %h exp %h", diff, e[W-1:0]); end
    checks++; if (borrow_out !== e[W])   begin errors++; $display("FAIL ignore_borrow got %b exp %b", borrow_out, e[W]); end
    take();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_extra_accept busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit quiet;
    send(8'h10, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (diff !== 8'h00)     begin errors++; $display("FAIL midrst_diff got %h exp 00", diff); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++; if (!quiet) begin errors++; $display("FAIL midrst_no_pulse got 1 exp 0"); end
    send(8'h10, 8'h01, 1'b0);
    wait_out(cyc);
    checks++; if (diff !== 8'h0F)      begin errors++; $display("FAIL midrst_rerun_diff got %h exp 0F", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_rerun_borrow got %b exp 0", borrow_out); end
    take();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va[3] = '{8'h80, 8'h7F, 8'h05};
    logic [W-1:0] vb[3] = '{8'h01, 8'hFF, 8'h03};
    logic [W-1:0] ed[3] = '{8'h7F, 8'h80, 8'h02};
    logic         eb[3] = '{1'b0, 1'b1, 1'b0};
    logic         eo[3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], 1'b0);
      wait_out(cyc);
      checks++; if (diff !== ed[i])       begin errors++; $display("FAIL ovf_diff[%0d] got %h exp %h", i, diff, ed[i]); end
      checks++; if (borrow_out !== eb[i]) begin errors++; $display("FAIL ovf_borrow[%0d] got %b exp %b", i, borrow_out, eb[i]); end
      checks++; if (ovf !== eo[i])        begin errors++; $display("FAIL ovf_flag[%0d] got %b exp %b", i, ovf, eo[i]); end
      take();
    end
  endtask
`endif

  task automatic test_back_to_back();
    int cyc;
    int last;
    int got;
    int pushed;
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    exp_q.delete();
    cyc = 0; last = -1; got = 0; pushed = 0;
    out_ready = 1'b1;
    while (got < 10 && cyc < 400) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_unexpected_result got %h exp none", diff);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (diff !== e[W-1:0] || borrow_out !== e[W]) begin
            errors++;
            $display("FAIL b2b_result[%0d] got %h/%b exp %h/%b", got, diff, borrow_out, e[W-1:0], e[W]);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != W + 2) begin
            errors++;
            $display("FAIL b2b_interval got %0d exp %0d", cyc - last, W + 2);
          end
        end
        last = cyc;
        got++;
      end
      if (in_ready === 1'b1) begin
        if (pushed < 10) begin
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
          a = ra; b = rb; borrow_in = rc; in_valid = 1'b1;
          exp_q.push_back(ref_model(ra, rb, rc));
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != 10) begin errors++; $display("FAIL b2b_count got %0d exp 10", got); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc;
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: ra = '1;
        2: rb = '0;
        3: rb = '1;
        4: rb = ra;
        default: ;
      endcase
      e = ref_model(ra, rb, rc);
      send(ra, rb, rc);
      wait_out(cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (diff !== e[W-1:0] || borrow_out !== e[W]) begin
        errors++;
        if (bad < 10) $display("FAIL random[%0d] a=%h b=%h bin=%b got %h/%b exp %h/%b",
                               i, ra, rb, rc, diff, borrow_out, e[W-1:0], e[W]);
        bad++;
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== e[W+1]) begin
        errors++;
        if (bad < 10) $display("FAIL random_ovf[%0d] a=%h b=%h bin=%b got %b exp %b",
                               i, ra, rb, rc, ovf, e[W+1]);
        bad++;
      end
`endif
      take();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_pressure();
    test_in_valid_ignored();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
